hazard_stall_controller: RTL and testbench

- Pipeline sequencer for the 5-stage datapath.
- Generates the PC and IF/ID enables, the ID/EX bubble insert and the IF/ID flush.
- Detects load-use hazards and schedules the shared multi-cycle HI/LO multiply/divide unit, stalling dependent instructions until it completes.
- Sits beside the ID stage; its stall/flush outputs gate the pipeline registers upstream of MEM/WB.

---
 rtl/hazard_stall_controller.sv | 106 ++++++++++
 tb/tb_hazard_stall_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use and HI/LO mult/div hazard stalls, IF/ID flush,
// and scheduling of the shared multi-cycle mult/div unit.
module hazard_stall_controller #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_md_start,
    input  logic             id_hilo_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_rf_enable,
    input  logic             branch_taken,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    // Counter is loaded with LATENCY-1 so md_done lands LATENCY cycles after accept.
    localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 1);

    state_t           state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             load_haz, md_haz, stall;

    // Hazard detection; r0 never creates a dependency.
    always_comb begin
        load_haz = id_valid & ex_mem_read & ex_rf_enable & (ex_rd != 5'd0) &
                   ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
        md_haz   = id_valid & (state_q == MD_BUSY) & (id_md_start | id_hilo_read);
        stall    = load_haz | md_haz;
    end

    // Pipeline control; reset forces a frozen, flushed, bubbled pipe.
    always_comb begin
        pc_enable   = ~stall & ~reset;
        ifid_enable = ~stall & ~reset;
        idex_bubble = stall | reset;
        ifid_flush  = reset | (branch_taken & id_valid & ~stall);
    end

    // Mult/div FSM next state and status outputs.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        md_busy  = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            RUN: begin
                if (id_valid & id_md_start & ~load_haz) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_INIT;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                if (md_cnt_q != 8'd0) begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end else begin
                    md_done = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            md_busy = 1'b0;
            md_done = 1'b0;
        end
    end

    // Saturating stall counter next value.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    // State registers; reset aborts any in-flight mult/div without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            md_cnt_q      <= 8'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: per-cycle vector table plus handwritten latency and saturation runs.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0, id_uses_rt = 1'b0, id_md_start = 1'b0, id_hilo_read = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       ex_mem_read = 1'b0, ex_rf_enable = 1'b0, branch_taken = 1'b0;

    logic        pc_enable, ifid_enable, idex_bubble, ifid_flush, md_busy, md_done;
    logic [15:0] stall_count;
    logic        s_pc, s_ifid, s_bub, s_fl, s_busy, s_done;
    logic [3:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MD_LATENCY(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_md_start(id_md_start), .id_hilo_read(id_hilo_read),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_rf_enable(ex_rf_enable),
        .branch_taken(branch_taken), .pc_enable(pc_enable), .ifid_enable(ifid_enable),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .md_busy(md_busy),
        .md_done(md_done), .stall_count(stall_count)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    hazard_stall_controller #(.MD_LATENCY(8), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_md_start(id_md_start), .id_hilo_read(id_hilo_read),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_rf_enable(ex_rf_enable),
        .branch_taken(branch_taken), .pc_enable(s_pc), .ifid_enable(s_ifid),
        .idex_bubble(s_bub), .ifid_flush(s_fl), .md_busy(s_busy),
        .md_done(s_done), .stall_count(s_cnt)
    );

    typedef struct {
        logic       rst, vld;
        logic [4:0] rs, rt;
        logic       urt, mds, hlr;
        logic [4:0] exrd;
        logic       exmr, exrf, br;
        logic       pc, bub, fl, busy, done;
        int         cnt;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic vld, logic [4:0] rs, logic [4:0] rt,
                                logic urt, logic mds, logic hlr, logic [4:0] exrd,
                                logic exmr, logic exrf, logic br, logic pc, logic bub,
                                logic fl, logic busy, logic done, int cnt, string name);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rs = rs; v.rt = rt; v.urt = urt; v.mds = mds;
        v.hlr = hlr; v.exrd = exrd; v.exmr = exmr; v.exrf = exrf; v.br = br;
        v.pc = pc; v.bub = bub; v.fl = fl; v.busy = busy; v.done = done;
        v.cnt = cnt; v.name = name;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt;
        id_md_start = v.mds; id_hilo_read = v.hlr; ex_rd = v.exrd; ex_mem_read = v.exmr;
        ex_rf_enable = v.exrf; branch_taken = v.br;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,"idle"));
    endtask

    initial begin
        logic [5:0] got, exp;
        int lat;
        // fields: rst vld rs rt urt mds hlr exrd exmr exrf br | pc bub fl busy done cnt
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,1,1,0,0,0,"reset_state"));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,"idle_run"));
        tbl.push_back(mk(0,1,8,0,0,0,0,8,1,1,0, 0,1,0,0,0,0,"load_use_rs"));
        tbl.push_back(mk(0,1,8,0,0,0,0,8,0,1,0, 1,0,0,0,0,1,"load_use_release"));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,1,1,0, 1,0,0,0,0,1,"load_r0_nostall"));
        tbl.push_back(mk(0,1,3,9,1,0,0,9,1,1,0, 0,1,0,0,0,1,"load_use_rt"));
        tbl.push_back(mk(0,1,3,9,0,0,0,9,1,1,0, 1,0,0,0,0,2,"rt_unused"));
        tbl.push_back(mk(0,1,8,0,0,0,0,8,1,0,0, 1,0,0,0,0,2,"load_no_rf_write"));
        tbl.push_back(mk(0,0,8,0,0,0,0,8,1,1,0, 1,0,0,0,0,2,"id_invalid"));
        tbl.push_back(mk(0,1,1,2,0,0,0,5,0,0,1, 1,0,1,0,0,2,"branch_flush"));
        tbl.push_back(mk(0,1,8,0,0,0,0,8,1,1,1, 0,1,0,0,0,2,"branch_in_stall"));
        tbl.push_back(mk(0,1,8,0,0,0,0,8,0,1,1, 1,0,1,0,0,3,"branch_retry"));
        tbl.push_back(mk(0,1,0,0,0,1,0,0,0,0,0, 1,0,0,0,0,3,"mult_accept"));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,1,0,3,"md_cycle1"));
        for (int c = 2; c <= 8; c++)
            tbl.push_back(mk(0,1,0,0,0,0,1,0,0,0,0, 0,1,0,1,(c == 8),1 + c,"mflo_wait"));
        tbl.push_back(mk(0,1,0,0,0,0,1,0,0,0,0, 1,0,0,0,0,10,"mflo_proceed"));
        tbl.push_back(mk(0,1,8,0,0,1,0,8,1,1,0, 0,1,0,0,0,10,"mult_vs_load"));
        tbl.push_back(mk(0,1,8,0,0,1,0,8,0,1,0, 1,0,0,0,0,11,"mult_accept2"));
        for (int c = 1; c <= 8; c++)
            tbl.push_back(mk(0,1,0,0,0,1,0,0,0,0,0, 0,1,0,1,(c == 8),10 + c,"b2b_mult_wait"));
        tbl.push_back(mk(0,1,0,0,0,1,0,0,0,0,0, 1,0,0,0,0,19,"b2b_mult_accept"));
        for (int c = 1; c <= 3; c++)
            tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,1,0,19,"div_busy"));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,1,1,0,0,19,"reset_mid_div"));
        for (int c = 0; c < 9; c++)
            tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,"post_reset_no_done"));

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            #3;
            got = {pc_enable, ifid_enable, idex_bubble, ifid_flush, md_busy, md_done};
            exp = {tbl[i].pc, tbl[i].pc, tbl[i].bub, tbl[i].fl, tbl[i].busy, tbl[i].done};
            n_vec++;
            if (got !== exp || int'(stall_count) != tbl[i].cnt) begin
                n_err++;
                $display("FAIL %s row %0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                         tbl[i].name, i, got, stall_count, exp, tbl[i].cnt);
            end
        end

        // md_done latency from the accept edge, bounded wait.
        @(posedge clk); #1;
        drive(mk(0,1,0,0,0,1,0,0,0,0,0, 1,0,0,0,0,0,"lat"));
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            idle();
            #3;
            if (md_done === 1'b1) begin lat = k; break; end
        end
        n_vec++;
        if (lat != 8) begin
            n_err++;
            $display("FAIL md_done_latency: got %0d cycles (0 = timeout), want 8", lat);
        end

        // Saturation: mult held in ID for 30 cycles from RUN -> 4 accepts, 26 stalls.
        @(posedge clk); #1;
        idle();
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            drive(mk(0,1,0,0,0,1,0,0,0,0,0, 1,0,0,0,0,0,"sat"));
        end
        @(posedge clk); #1;
        idle();
        #3;
        n_vec++;
        if (s_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL sat_cnt4: got %0d, want 15", s_cnt);
        end
        n_vec++;
        if (stall_count !== 16'd26) begin
            n_err++;
            $display("FAIL cnt16_after_sat: got %0d, want 26", stall_count);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
